spi_frame_rx: RTL and testbench

- Upstream receive front end for the SPI register bank.
- Synchronises the raw SCLK/COPI/nCS pins into the clk domain, detects edges, and assembles 16-bit MSB-first frames.
- Each frame is 1 R/W bit, a 7-bit address and 8 data bits.
- Validated frames are presented on a valid/ready port to the register-write logic, which drives the output-enable, PWM-enable and duty-cycle registers consumed by the PWM peripheral.
- Malformed or dropped frames are flagged.

---
 rtl/spi_frame_pkg.sv | 26 ++
 rtl/spi_frame_rx_sync_edge.sv | 29 ++
 rtl/spi_frame_rx.sv | 99 +++++++++
 tb/tb_spi_frame_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants, frame layout and receive FSM encoding for the SPI frame receiver.
package spi_frame_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Counter must hold FRAME_BITS+1 so that over-long frames stay distinguishable.
  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACTIVE
  } rx_state_t;
endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop pin synchroniser with a history flop producing single-cycle rise/fall strobes.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;
endmodule

// File: rtl/spi_frame_rx.sv
// SPI receive front end: synchronises pins, assembles MSB-first frames and offers them
// on a one-deep valid/ready slot with length and overrun error pulses.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              copi_in,
  input  logic              ncs_in,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_rw,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              busy,
  output logic              err_len,
  output logic              err_overrun,
  output rx_state_t         rx_state
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic unused_strobes;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .raw(sclk_in), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .raw(copi_in), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .raw(ncs_in), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

  assign unused_strobes = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  spi_frame_t            frame_q;
  logic                  slot_free;

  // A pop on the completion edge frees the slot for the incoming frame.
  assign slot_free = ~frame_valid | frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      busy        <= ~ncs_lvl;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      case (rx_state)
        RX_IDLE: begin
          if (ncs_fall) begin
            rx_state <= RX_ACTIVE;
            shift_q  <= '0;
            cnt_q    <= '0;
          end
        end
        RX_ACTIVE: begin
          // nCS rise takes priority, so a coincident SCLK rise is not counted.
          if (ncs_rise) begin
            rx_state <= RX_IDLE;
            if (cnt_q != CNT_FULL) begin
              err_len <= 1'b1;
            end else if (slot_free) begin
              frame_q.rw   <= shift_q[RW_BIT];
              frame_q.addr <= shift_q[ADDR_MSB:ADDR_LSB];
              frame_q.data <= shift_q[DATA_MSB:DATA_LSB];
              frame_valid  <= 1'b1;
            end else begin
              err_overrun <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign frame_rw   = frame_q.rw;
  assign frame_addr = frame_q.addr;
  assign frame_data = frame_q.data;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: drives SPI pin waveforms and compares against a frame-level model.
module tb_spi_frame_rx;
  import spi_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in, copi_in, ncs_in, frame_ready;
  logic       frame_valid, frame_rw, busy, err_len, err_overrun;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  rx_state_t  rx_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed activity, collected away from the active edge.
  int          len_seen = 0, ovr_seen = 0, valid_cycles = 0;
  logic [15:0] got_q[$];

  // Reference model: one-deep slot plus expected error counts and accepted frames.
  logic [15:0] exp_q[$];
  int          exp_len = 0, exp_ovr = 0;
  bit          model_full = 0;
  logic [15:0] model_slot = '0;

  always #5 clk = ~clk;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .copi_in(copi_in), .ncs_in(ncs_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_rw(frame_rw),
    .frame_addr(frame_addr), .frame_data(frame_data), .busy(busy),
    .err_len(err_len), .err_overrun(err_overrun), .rx_state(rx_state));

  always @(negedge clk) begin
    if (!rst) begin
      if (err_len) len_seen++;
      if (err_overrun) ovr_seen++;
      if (frame_valid) valid_cycles++;
      if (frame_valid && frame_ready) got_q.push_back({frame_rw, frame_addr, frame_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Lowers nCS and clocks out the low nbits of word MSB first; leaves nCS low.
  task automatic send_bits(input logic [31:0] word, input int nbits);
    ncs_in = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi_in = word[i];
      tick(4);
      sclk_in = 1'b1;
      tick(4);
      sclk_in = 1'b0;
    end
    tick(4);
  endtask

  task automatic model_pop();
    if (model_full) begin
      exp_q.push_back(model_slot);
      model_full = 0;
    end
  endtask

  // Completion rules at nCS rise; pop_now means the consumer accepts on that same edge.
  task automatic model_complete(input logic [31:0] word, input int nbits, input bit pop_now);
    if (nbits != 16) begin
      exp_len++;
      if (pop_now) model_pop();
    end else if (model_full && !pop_now) begin
      exp_ovr++;
    end else begin
      if (pop_now) model_pop();
      model_full = 1;
      model_slot = word[15:0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk_in = 1'b0; copi_in = 1'b0; ncs_in = 1'b1; frame_ready = 1'b1;
    tick(3);
    n_checks++;
    if ({frame_valid, frame_rw, frame_addr, frame_data, busy, err_len, err_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {frame_valid, frame_rw, frame_addr, frame_data, busy, err_len, err_overrun});
    end
    n_checks++;
    if (rx_state !== RX_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", rx_state, RX_IDLE);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single_write();
    int lat = 0;
    int vc0 = valid_cycles;
    logic [15:0] seen;
    frame_ready = 1'b1;
    send_bits(32'h8012, 16);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b required 1", busy); end
    ncs_in = 1'b1;
    model_complete(32'h8012, 16, 1);
    model_pop();
    seen = '0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (frame_valid) begin lat = k; seen = {frame_rw, frame_addr, frame_data}; break; end
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL valid_latency: got %0d edges required 3", lat); end
    n_checks++;
    if (seen !== 16'h8012) begin n_fail++; $display("FAIL write_fields: got %h required 8012", seen); end
    tick(6);
    n_checks++;
    if (valid_cycles - vc0 !== 1) begin
      n_fail++; $display("FAIL valid_pulse_width: got %0d required 1", valid_cycles - vc0);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b required 0", busy); end
  endtask

  task automatic test_overrun();
    frame_ready = 1'b0;
    send_bits(32'h8104, 16); ncs_in = 1'b1; model_complete(32'h8104, 16, 0); tick(6);
    n_checks++;
    if ({frame_valid, frame_rw, frame_addr, frame_data} !== {1'b1, 16'h8104}) begin
      n_fail++; $display("FAIL held_frame: got %b_%h required 1_8104", frame_valid,
                         {frame_rw, frame_addr, frame_data});
    end
    send_bits(32'h8204, 16); ncs_in = 1'b1; model_complete(32'h8204, 16, 0); tick(6);
    n_checks++;
    if ({frame_rw, frame_addr, frame_data} !== 16'h8104) begin
      n_fail++; $display("FAIL held_after_overrun: got %h required 8104", {frame_rw, frame_addr, frame_data});
    end
    n_checks++;
    if (ovr_seen !== exp_ovr) begin n_fail++; $display("FAIL overrun_count: got %0d required %0d", ovr_seen, exp_ovr); end
    frame_ready = 1'b1; model_pop();
    tick(1);
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL valid_after_pop: got %b required 0", frame_valid); end
    tick(6);
  endtask

  task automatic test_bad_length();
    int vc0 = valid_cycles;
    frame_ready = 1'b1;
    send_bits(32'h1234, 15); ncs_in = 1'b1; model_complete(32'h1234, 15, 1); tick(6);
    send_bits(32'h1ABCD, 17); ncs_in = 1'b1; model_complete(32'h1ABCD, 17, 1); tick(6);
    n_checks++;
    if (len_seen !== exp_len) begin n_fail++; $display("FAIL len_err_count: got %0d required %0d", len_seen, exp_len); end
    n_checks++;
    if (valid_cycles !== vc0) begin n_fail++; $display("FAIL valid_on_bad_len: got %0d cycles required 0", valid_cycles - vc0); end
    send_bits(32'h0300, 16); ncs_in = 1'b1; model_complete(32'h0300, 16, 1); model_pop(); tick(6);
  endtask

  task automatic test_idle_toggle();
    int vc0 = valid_cycles;
    int le0 = len_seen;
    int busy_hits = 0;
    frame_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sclk_in = 1'($urandom_range(0, 1));
      copi_in = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 4));
      if (busy !== 1'b0 || rx_state !== RX_IDLE) busy_hits++;
    end
    sclk_in = 1'b0;
    tick(4);
    n_checks++;
    if (busy_hits !== 0 || valid_cycles !== vc0 || len_seen !== le0) begin
      n_fail++; $display("FAIL idle_activity: got busy/active=%0d valid=%0d len=%0d required 0 0 0",
                         busy_hits, valid_cycles - vc0, len_seen - le0);
    end
    send_bits(32'h84FF, 16); ncs_in = 1'b1; model_complete(32'h84FF, 16, 1); model_pop(); tick(6);
  endtask

  task automatic test_reset_midframe();
    int vc0;
    frame_ready = 1'b1;
    send_bits(32'hC3, 8);
    rst = 1'b1; ncs_in = 1'b1; sclk_in = 1'b0; copi_in = 1'b0;
    model_full = 0;
    tick(3);
    rst = 1'b0;
    vc0 = valid_cycles;
    tick(8);
    n_checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || rx_state !== RX_IDLE || valid_cycles !== vc0) begin
      n_fail++; $display("FAIL after_abort: got valid=%b busy=%b state=%0d required 0 0 0",
                         frame_valid, busy, rx_state);
    end
    send_bits(32'h8255, 16); ncs_in = 1'b1; model_complete(32'h8255, 16, 1); model_pop(); tick(6);
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b0;
    send_bits(32'h8111, 16); ncs_in = 1'b1; model_complete(32'h8111, 16, 0); tick(6);
    send_bits(32'h8322, 16);
    ncs_in = 1'b1;
    tick(2);
    frame_ready = 1'b1;
    model_complete(32'h8322, 16, 1);
    tick(1);
    frame_ready = 1'b0;
    n_checks++;
    if ({frame_valid, frame_rw, frame_addr, frame_data} !== {1'b1, 16'h8322}) begin
      n_fail++; $display("FAIL seamless_load: got %b_%h required 1_8322", frame_valid,
                         {frame_rw, frame_addr, frame_data});
    end
    tick(4);
    n_checks++;
    if (ovr_seen !== exp_ovr) begin n_fail++; $display("FAIL b2b_overrun: got %0d required %0d", ovr_seen, exp_ovr); end
    frame_ready = 1'b1; model_pop();
    tick(4);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          n;
    frame_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      w = $urandom;
      n = ($urandom_range(0, 2) != 0) ? 16 : $urandom_range(14, 18);
      send_bits(w, n);
      ncs_in = 1'b1;
      model_complete(w, n, 1);
      model_pop();
      tick($urandom_range(6, 10));
    end
  endtask

  task automatic test_scoreboard();
    logic [15:0] g, e;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL frame_data: got %h required %h", g, e); end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL frame_count: got %0d extra required %0d extra", got_q.size(), exp_q.size());
    end
    n_checks++;
    if (len_seen !== exp_len || ovr_seen !== exp_ovr) begin
      n_fail++; $display("FAIL error_totals: got len=%0d ovr=%0d required len=%0d ovr=%0d",
                         len_seen, ovr_seen, exp_len, exp_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overrun();
    test_bad_length();
    test_idle_toggle();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
